spi_wb_bridge: RTL



---
 rtl/spi_wb_bridge.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_wb_bridge.sv
// SPI-slave (mode 0) to Wishbone-master bridge: single/burst reads and writes with auto-increment,
// one WB cycle at a time, abandoned after TIMEOUT clocks without ack.
module spi_wb_bridge #(
  parameter int unsigned TIMEOUT     = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i,
  input  logic        spi_sclk_i,
  input  logic        spi_mosi_i,
  input  logic        spi_cs_ni,
  output logic        spi_miso_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RTURN, S_RDATA, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic sclk_d, cs_d;
  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c;

  logic [4:0]  bit_cnt;
  logic [31:0] rx_sr, tx_sr, addr, prefetch;
  logic [31:0] rx_word_c;
  logic        is_read;
  logic        last8_c, last32_c;

  logic        req_c, req_we_c, load_c, shift_c;
  logic [31:0] req_adr_c;

  logic          buf_valid, buf_we;
  logic [31:0]   buf_adr, buf_dat;
  logic          start_c, cap_c, st_we_c;
  logic [31:0]   st_adr_c, st_dat_c;
  logic [TW-1:0] to_cnt;

  // Input synchronizers; CS idles high so reset does not fake a falling edge
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_ni};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign sclk_rise_c = sclk_s & ~sclk_d;
  assign sclk_fall_c = ~sclk_s & sclk_d;
  assign cs_rise_c   = cs_s & ~cs_d;
  assign cs_fall_c   = ~cs_s & cs_d;
  assign rx_word_c   = {rx_sr[30:0], mosi_s};
  assign last8_c     = (bit_cnt == 5'd7);
  assign last32_c    = (bit_cnt == 5'd31);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_rise_c) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (cs_fall_c) state_nxt = S_CMD;
        S_CMD:   if (sclk_rise_c && last8_c)
                   state_nxt = (rx_word_c[7:0] == 8'h01 || rx_word_c[7:0] == 8'h02) ? S_ADDR : S_DONE;
        S_ADDR:  if (sclk_rise_c && last32_c) state_nxt = is_read ? S_RTURN : S_WDATA;
        S_RTURN: if (sclk_rise_c && last8_c) state_nxt = S_RDATA;
        default: state_nxt = state;
      endcase
    end
  end

  // WB launch requests and MISO load/shift strobes
  always_comb begin
    req_c     = 1'b0;
    req_we_c  = 1'b0;
    req_adr_c = addr;
    load_c    = 1'b0;
    shift_c   = 1'b0;
    if (!cs_rise_c) begin
      case (state)
        S_ADDR: if (sclk_rise_c && last32_c && is_read) begin
          req_c     = 1'b1;
          req_adr_c = rx_word_c;
        end
        S_WDATA: if (sclk_rise_c && last32_c) begin
          req_c    = 1'b1;
          req_we_c = 1'b1;
        end
        S_RDATA: if (sclk_fall_c) begin
          if (bit_cnt == 5'd0) begin
            load_c    = 1'b1;
            req_c     = 1'b1;
            req_adr_c = addr + 32'd4;
          end else begin
            shift_c = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      addr       <= '0;
      is_read    <= 1'b0;
      spi_miso_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      if (cs_fall_c) begin
        bit_cnt <= '0;
      end else if (sclk_rise_c && state != S_IDLE && state != S_DONE) begin
        rx_sr   <= rx_word_c;
        bit_cnt <= ((state == S_CMD || state == S_RTURN) && last8_c) ? 5'd0 : bit_cnt + 5'd1;
      end
      if (state == S_CMD && sclk_rise_c && last8_c)
        is_read <= (rx_word_c[7:0] == 8'h02);
      if (state == S_ADDR && sclk_rise_c && last32_c)
        addr <= rx_word_c;
      else if (req_c)
        addr <= addr + 32'd4;
      if (cs_rise_c || state != S_RDATA) begin
        spi_miso_o <= 1'b0;
      end else if (load_c) begin
        tx_sr      <= prefetch;
        spi_miso_o <= prefetch[31];
      end else if (shift_c) begin
        tx_sr      <= {tx_sr[30:0], 1'b0};
        spi_miso_o <= tx_sr[30];
      end
      busy_o <= (state != S_IDLE) || wbm_cyc_o || buf_valid;
    end
  end

  // A request arriving while the engine is busy waits in a one-entry buffer
  assign start_c  = !wbm_cyc_o && (buf_valid || req_c);
  assign cap_c    = req_c && (wbm_cyc_o || buf_valid);
  assign st_adr_c = buf_valid ? buf_adr : req_adr_c;
  assign st_dat_c = buf_valid ? buf_dat : rx_word_c;
  assign st_we_c  = buf_valid ? buf_we  : req_we_c;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      prefetch  <= '0;
      err_o     <= 1'b0;
      to_cnt    <= '0;
      buf_valid <= 1'b0;
      buf_we    <= 1'b0;
      buf_adr   <= '0;
      buf_dat   <= '0;
    end else begin
      if (cs_fall_c) err_o <= 1'b0;
      if (cap_c) begin
        buf_valid <= 1'b1;
        buf_we    <= req_we_c;
        buf_adr   <= req_adr_c;
        buf_dat   <= rx_word_c;
      end else if (start_c && buf_valid) begin
        buf_valid <= 1'b0;
      end
      if (start_c) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_sel_o <= 4'hF;
        wbm_we_o  <= st_we_c;
        wbm_adr_o <= st_adr_c;
        if (st_we_c) wbm_dat_o <= st_dat_c;
        to_cnt    <= '0;
      end else if (wbm_cyc_o) begin
        // ack is checked first so it wins over a simultaneous timeout
        if (wbm_ack_i) begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          wbm_we_o  <= 1'b0;
          wbm_sel_o <= 4'h0;
          if (!wbm_we_o) prefetch <= wbm_dat_i;
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          wbm_we_o  <= 1'b0;
          wbm_sel_o <= 4'h0;
          err_o     <= 1'b1;
          if (!wbm_we_o) prefetch <= '1;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end
    end
  end

endmodule
